// File: rtl/cave_input_ctrl.sv
// Player-input front end: PS/2 key events and MiSTer joysticks merged into
// SOCD-cleaned, coin-stretched, registered controls for the game core.
//
// Ports:
//   clk_sys, RESET (async, active-high)
//   ps2_key     [10] toggle, [9] pressed, [8] extended, [7:0] set-2 scan code
//   joystick_0/1  [0]R [1]L [2]D [3]U [4..6]B1..B3 [7]start [8]coin
//                 [9]pause [10]service
//   p1_*/p2_*   dir {U,D,L,R}, buttons {b3,b2,b1}, start, coin, pause
//   service     {service2, service1}
module cave_input_ctrl #(
    parameter int COIN_PULSE_LEN = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joystick_0,
    input  logic [31:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [2:0]  p1_buttons,
    output logic        p1_start,
    output logic        p1_coin,
    output logic        p1_pause,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p2_buttons,
    output logic        p2_start,
    output logic        p2_coin,
    output logic        p2_pause,
    output logic [1:0]  service
);

    // Key latch slots
    localparam int K1_U     = 0;
    localparam int K1_D     = 1;
    localparam int K1_L     = 2;
    localparam int K1_R     = 3;
    localparam int K1_B1    = 4;
    localparam int K1_B2    = 5;
    localparam int K1_B3    = 6;
    localparam int K1_START = 7;
    localparam int K1_COIN  = 8;
    localparam int K1_PAUSE = 9;
    localparam int K1_SVC   = 10;
    localparam int K2_U     = 11;
    localparam int K2_D     = 12;
    localparam int K2_L     = 13;
    localparam int K2_R     = 14;
    localparam int K2_B1    = 15;
    localparam int K2_B2    = 16;
    localparam int K2_B3    = 17;
    localparam int K2_START = 18;
    localparam int K2_COIN  = 19;
    localparam int K2_SVC   = 20;
    localparam int NKEYS    = 21;

    localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_PULSE_LEN - 1);

    logic             primed;
    logic             old_toggle;
    logic [NKEYS-1:0] key_q;
    logic [NKEYS-1:0] key_hit;
    logic             key_event;

    logic [1:0]       raw_coin;
    logic [1:0]       coin_prev;
    logic [CNT_W-1:0] coin_cnt [2];

    logic u1, d1, l1, r1;
    logic u2, d2, l2, r2;

    logic unused_bits;
    assign unused_bits = ^{joystick_0[31:11], joystick_1[31:11]};

    // The priming edge only captures the toggle level, so a toggle left
    // high across reset is not mistaken for a fresh event.
    assign key_event = primed && (ps2_key[10] != old_toggle);

    // One-hot decode of the scan code into a latch slot
    always_comb begin
        key_hit = '0;
        case (ps2_key[7:0])
            8'h14: key_hit[K1_B1] = 1'b1;
            8'h11: key_hit[K1_B2] = 1'b1;
            default: begin
                if (ps2_key[8]) begin
                    case (ps2_key[7:0])
                        8'h75:   key_hit[K1_U] = 1'b1;
                        8'h72:   key_hit[K1_D] = 1'b1;
                        8'h6B:   key_hit[K1_L] = 1'b1;
                        8'h74:   key_hit[K1_R] = 1'b1;
                        default: key_hit = '0;
                    endcase
                end else begin
                    case (ps2_key[7:0])
                        8'h29:   key_hit[K1_B3]    = 1'b1;
                        8'h16:   key_hit[K1_START] = 1'b1;
                        8'h2E:   key_hit[K1_COIN]  = 1'b1;
                        8'h4D:   key_hit[K1_PAUSE] = 1'b1;
                        8'h46:   key_hit[K1_SVC]   = 1'b1;
                        8'h2D:   key_hit[K2_U]     = 1'b1;
                        8'h2B:   key_hit[K2_D]     = 1'b1;
                        8'h23:   key_hit[K2_L]     = 1'b1;
                        8'h34:   key_hit[K2_R]     = 1'b1;
                        8'h1C:   key_hit[K2_B1]    = 1'b1;
                        8'h1B:   key_hit[K2_B2]    = 1'b1;
                        8'h15:   key_hit[K2_B3]    = 1'b1;
                        8'h1E:   key_hit[K2_START] = 1'b1;
                        8'h36:   key_hit[K2_COIN]  = 1'b1;
                        8'h45:   key_hit[K2_SVC]   = 1'b1;
                        default: key_hit = '0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            primed     <= 1'b0;
            old_toggle <= 1'b0;
            key_q      <= '0;
        end else begin
            primed     <= 1'b1;
            old_toggle <= ps2_key[10];
            if (key_event) begin
                key_q <= (key_q & ~key_hit) | (key_hit & {NKEYS{ps2_key[9]}});
            end
        end
    end

    // Raw directions: keyboard OR joystick
    assign u1 = key_q[K1_U] | joystick_0[3];
    assign d1 = key_q[K1_D] | joystick_0[2];
    assign l1 = key_q[K1_L] | joystick_0[1];
    assign r1 = key_q[K1_R] | joystick_0[0];
    assign u2 = key_q[K2_U] | joystick_1[3];
    assign d2 = key_q[K2_D] | joystick_1[2];
    assign l2 = key_q[K2_L] | joystick_1[1];
    assign r2 = key_q[K2_R] | joystick_1[0];

    assign raw_coin = {key_q[K2_COIN] | joystick_1[8],
                       key_q[K1_COIN] | joystick_0[8]};

    // Coin stretch: a rising edge arms a countdown only when idle;
    // edges during a running stretch neither reload nor extend it.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            coin_prev <= '0;
            for (int i = 0; i < 2; i++) begin
                coin_cnt[i] <= '0;
            end
        end else begin
            coin_prev <= raw_coin;
            for (int i = 0; i < 2; i++) begin
                if (raw_coin[i] && !coin_prev[i] && coin_cnt[i] == '0) begin
                    coin_cnt[i] <= COIN_LOAD;
                end else if (coin_cnt[i] != '0) begin
                    coin_cnt[i] <= coin_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Output registers; opposing directions cancel (SOCD neutral)
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            p1_dir     <= '0;
            p1_buttons <= '0;
            p1_start   <= 1'b0;
            p1_coin    <= 1'b0;
            p1_pause   <= 1'b0;
            p2_dir     <= '0;
            p2_buttons <= '0;
            p2_start   <= 1'b0;
            p2_coin    <= 1'b0;
            p2_pause   <= 1'b0;
            service    <= '0;
        end else begin
            p1_dir     <= {u1 & ~d1, d1 & ~u1, l1 & ~r1, r1 & ~l1};
            p1_buttons <= {key_q[K1_B3] | joystick_0[6],
                           key_q[K1_B2] | joystick_0[5],
                           key_q[K1_B1] | joystick_0[4]};
            p1_start   <= key_q[K1_START] | joystick_0[7];
            p1_coin    <= (coin_cnt[0] != '0) | raw_coin[0];
            p1_pause   <= key_q[K1_PAUSE] | joystick_0[9];
            p2_dir     <= {u2 & ~d2, d2 & ~u2, l2 & ~r2, r2 & ~l2};
            p2_buttons <= {key_q[K2_B3] | joystick_1[6],
                           key_q[K2_B2] | joystick_1[5],
                           key_q[K2_B1] | joystick_1[4]};
            p2_start   <= key_q[K2_START] | joystick_1[7];
            p2_coin    <= (coin_cnt[1] != '0) | raw_coin[1];
            p2_pause   <= joystick_1[9];
            service    <= {key_q[K2_SVC] | joystick_1[10],
                           key_q[K1_SVC] | joystick_0[10]};
        end
    end

endmodule

// File: tb/tb_cave_input_ctrl.sv
// Randomized bench for cave_input_ctrl against a cycle-level reference
// model built from the key map, SOCD and coin-stretch rules.
module tb_cave_input_ctrl;

    localparam int LEN = 8;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [10:0] ps2_key;
    logic [31:0] joystick_0;
    logic [31:0] joystick_1;
    logic [3:0]  p1_dir;
    logic [2:0]  p1_buttons;
    logic        p1_start;
    logic        p1_coin;
    logic        p1_pause;
    logic [3:0]  p2_dir;
    logic [2:0]  p2_buttons;
    logic        p2_start;
    logic        p2_coin;
    logic        p2_pause;
    logic [1:0]  service;

    cave_input_ctrl #(.COIN_PULSE_LEN(LEN), .CNT_W(4)) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .p1_dir     (p1_dir),
        .p1_buttons (p1_buttons),
        .p1_start   (p1_start),
        .p1_coin    (p1_coin),
        .p1_pause   (p1_pause),
        .p2_dir     (p2_dir),
        .p2_buttons (p2_buttons),
        .p2_start   (p2_start),
        .p2_coin    (p2_coin),
        .p2_pause   (p2_pause),
        .service    (service)
    );

    always #5 clk_sys = ~clk_sys;

    logic [21:0] act_v;
    assign act_v = {p1_dir, p1_buttons, p1_start, p1_coin, p1_pause,
                    p2_dir, p2_buttons, p2_start, p2_coin, p2_pause, service};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: held keys per function, player p uses slots
    // 11*p + {U,D,L,R,B1,B2,B3,START,COIN,PAUSE,SVC}.
    bit          held [22];
    bit          m_primed;
    bit          m_old;
    int          cyc;
    int          cend [2];
    bit          cprev [2];
    logic [21:0] exp_v;

    function automatic int keymap(bit ext, bit [7:0] code);
        if (code == 8'h14) return 4;
        if (code == 8'h11) return 5;
        if (ext) begin
            case (code)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (code)
            8'h29: return 6;
            8'h16: return 7;
            8'h2E: return 8;
            8'h4D: return 9;
            8'h46: return 10;
            8'h2D: return 11;
            8'h2B: return 12;
            8'h23: return 13;
            8'h34: return 14;
            8'h1C: return 15;
            8'h1B: return 16;
            8'h15: return 17;
            8'h1E: return 18;
            8'h36: return 19;
            8'h45: return 21;
            default: return -1;
        endcase
    endfunction

    task automatic m_clear();
        foreach (held[i]) held[i] = 1'b0;
        m_primed = 1'b0;
        m_old    = 1'b0;
        cend[0]  = 0;
        cend[1]  = 0;
        cprev[0] = 1'b0;
        cprev[1] = 1'b0;
        exp_v    = '0;
    endtask

    task automatic model_edge();
        bit [31:0] j [2];
        bit [3:0]  dir [2];
        bit [2:0]  btn [2];
        bit        st [2], cn [2], pa [2], sv [2];
        bit        u, d, l, r, rc;
        int        b, k;
        if (RESET) begin
            m_clear();
            return;
        end
        cyc++;
        j[0] = joystick_0;
        j[1] = joystick_1;
        for (int p = 0; p < 2; p++) begin
            b = 11 * p;
            u = held[b]   | j[p][3];
            d = held[b+1] | j[p][2];
            l = held[b+2] | j[p][1];
            r = held[b+3] | j[p][0];
            dir[p] = {u && !d, d && !u, l && !r, r && !l};
            btn[p] = {held[b+6] | j[p][6], held[b+5] | j[p][5], held[b+4] | j[p][4]};
            st[p]  = held[b+7] | j[p][7];
            pa[p]  = held[b+9] | j[p][9];
            sv[p]  = held[b+10] | j[p][10];
            rc     = held[b+8] | j[p][8];
            if (rc && !cprev[p] && cyc >= cend[p]) cend[p] = cyc + LEN;
            cn[p]    = rc | (cyc < cend[p]);
            cprev[p] = rc;
        end
        exp_v = {dir[0], btn[0], st[0], cn[0], pa[0],
                 dir[1], btn[1], st[1], cn[1], pa[1], sv[1], sv[0]};
        if (m_primed && ps2_key[10] != m_old) begin
            k = keymap(ps2_key[8], ps2_key[7:0]);
            if (k >= 0) held[k] = ps2_key[9];
        end
        m_primed = 1'b1;
        m_old    = ps2_key[10];
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        chk("vec", 32'(act_v), 32'(exp_v));
    endtask

    task automatic send_key(input bit ext, input bit [7:0] code, input bit pr);
        ps2_key = {~ps2_key[10], pr, ext, code};
    endtask

    logic [7:0] codes [22] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11,
                               8'h29, 8'h16, 8'h1E, 8'h2E, 8'h36, 8'h46,
                               8'h45, 8'h1C, 8'h1B, 8'h15, 8'h2D, 8'h2B,
                               8'h23, 8'h34, 8'h4D, 8'h5A};

    int hi;

    initial begin
        cyc        = 0;
        RESET      = 1'b1;
        ps2_key    = 11'h400;
        joystick_0 = '0;
        joystick_1 = '0;
        m_clear();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst", 32'(act_v), 32'h0);
        RESET = 1'b0;

        // stale toggle level must not decode
        repeat (10) step();
        chk("idle", 32'(act_v), 32'h0);
        send_key(1'b1, 8'h75, 1'b1);
        step();
        chk("up_lat", 32'(p1_dir), 32'h0);
        step();
        chk("up_key", 32'(p1_dir), 32'h8);

        // extended-only and either-ext codes
        send_key(1'b1, 8'h75, 1'b0);
        repeat (2) step();
        send_key(1'b0, 8'h75, 1'b1);
        repeat (2) step();
        chk("up_noext", 32'(p1_dir), 32'h0);
        send_key(1'b0, 8'h14, 1'b1);
        repeat (2) step();
        chk("ctrl_e0", 32'(p1_buttons[0]), 32'h1);
        send_key(1'b0, 8'h14, 1'b0);
        repeat (2) step();
        send_key(1'b1, 8'h14, 1'b1);
        repeat (2) step();
        chk("ctrl_e1", 32'(p1_buttons[0]), 32'h1);
        send_key(1'b1, 8'h14, 1'b0);
        step();
        chk("ctrl_hold", 32'(p1_buttons[0]), 32'h1);
        step();
        chk("ctrl_rel", 32'(p1_buttons[0]), 32'h0);

        // SOCD on joystick
        joystick_0[3:2] = 2'b11;
        step();
        chk("socd", 32'(p1_dir[3:2]), 32'h0);
        joystick_0[2] = 1'b0;
        step();
        chk("socd_rel", 32'(p1_dir), 32'h8);
        joystick_0 = '0;
        step();

        // coin stretch, retrigger ignored, then fresh pulse
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            joystick_1[8] = (i == 0 || i == 3);
            step();
            hi += int'(p2_coin);
        end
        chk("coin_len", 32'(hi), 32'(LEN));
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            joystick_1[8] = (i == 0);
            step();
            hi += int'(p2_coin);
        end
        chk("coin_len2", 32'(hi), 32'(LEN));

        // service from key and joystick
        send_key(1'b0, 8'h46, 1'b1);
        joystick_1[10] = 1'b1;
        repeat (2) step();
        chk("svc", 32'(service), 32'h3);
        send_key(1'b0, 8'h46, 1'b0);
        repeat (2) step();
        chk("svc_rel", 32'(service), 32'h2);
        joystick_1[10] = 1'b0;
        step();

        // reset during a stretch
        joystick_1[8] = 1'b1;
        step();
        joystick_1[8] = 1'b0;
        repeat (2) step();
        chk("coin_pre", 32'(p2_coin), 32'h1);
        #2;
        RESET = 1'b1;
        m_clear();
        #1;
        chk("rst_async", 32'(act_v), 32'h0);
        repeat (2) step();
        RESET = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hi += int'(p2_coin);
        end
        chk("no_resid", 32'(hi), 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_key(1'($urandom), codes[$urandom_range(0, 21)], 1'($urandom));
            end else if ($urandom_range(0, 7) == 0) begin
                ps2_key[9:0] = 10'($urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    joystick_0[$urandom_range(0, 10)] ^= 1'b1;
                else
                    joystick_1[$urandom_range(0, 10)] ^= 1'b1;
            end
            if ($urandom_range(0, 63) == 0) begin
                joystick_0[31:11] = 21'($urandom);
                joystick_1[31:11] = 21'($urandom);
            end
            if ($urandom_range(0, 999) == 0) begin
                RESET = 1'b1;
                m_clear();
                #1;
                chk("rnd_rst", 32'(act_v), 32'h0);
                step();
                RESET = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
